// File: rtl/gray_code_pkg.sv
// Shared gray-code helpers and FSM state type for the gray pointer crossing.
// Contents:
//   MAX_WIDTH       widest pointer the conversion helpers accept
//   state_t         receiver FSM states (FILL, RUN)
//   gray_to_binary  gray -> binary; zero-extend narrower pointers, truncate the result
//   binary_to_gray  binary -> gray, for the write-side encoder
package gray_code_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // binary[k] is the XOR of gray[MSB:k]. Zero upper bits leave the low bits unaffected.
    function automatic logic [MAX_WIDTH-1:0] gray_to_binary(input logic [MAX_WIDTH-1:0] gray);
        logic [MAX_WIDTH-1:0] bin;
        bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
        for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] binary_to_gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_synchronizer.sv
// Multi-flop synchronizer for a gray-coded bus arriving from a foreign clock domain.
// This module is kept separate so that timing constraints can target these flops.
// Ports:
//   clk, rst_n  receive-domain clock and asynchronous active-low reset
//   d           gray-coded bus, asynchronous to clk
//   q           output of the last synchronizer stage
module gray_synchronizer #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    // Plain shift chain. Stage 0 is the flop that may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gray_pointer_receiver.sv
// Receive side of a gray-coded pointer crossing. It synchronizes gray_in, decodes it,
// reports the advance since the previous sample, and flags multi-bit jumps (sticky).
// Ports:
//   clk, rst_n  receive-domain clock and asynchronous active-low reset
//   gray_in     foreign-domain gray pointer
//   clear       synchronous restart: clears error and re-enters FILL
//   binary_out  decoded synchronized pointer
//   delta       advance since the previous sample, mod 2^WIDTH
//   advanced    delta is nonzero
//   valid       outputs reflect a fully synchronized sample
//   error       sticky flag: more than one bit changed between samples
module gray_pointer_receiver
    import gray_code_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] delta,
    output logic             advanced,
    output logic             valid,
    output logic             error
);

    localparam int unsigned     CNT_W     = $clog2(SYNC_STAGES) + 1;
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SYNC_STAGES - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] synced, prev;
    logic [WIDTH-1:0] bin_synced, bin_prev;
    logic             multi_change;

    logic [WIDTH-1:0] binary_d, delta_d;
    logic             advanced_d, valid_d, error_d;

    gray_synchronizer #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gray_in),
        .q     (synced)
    );

    // Decode the current and the previous synchronized sample.
    assign bin_synced   = WIDTH'(gray_to_binary(MAX_WIDTH'(synced)));
    assign bin_prev     = WIDTH'(gray_to_binary(MAX_WIDTH'(prev)));
    assign multi_change = ($countones(synced ^ prev) > 1);

    // State, fill counter, sample history and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            cnt        <= '0;
            prev       <= '0;
            binary_out <= '0;
            delta      <= '0;
            advanced   <= 1'b0;
            valid      <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            prev       <= synced;
            binary_out <= binary_d;
            delta      <= delta_d;
            advanced   <= advanced_d;
            valid      <= valid_d;
            error      <= error_d;
        end
    end

    // Next state: FILL counts SYNC_STAGES cycles. clear always restarts the fill.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            FILL: begin
                if (clear) begin
                    cnt_next = '0;
                end else if (cnt == FILL_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = FILL;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs. delta and error are evaluated only in RUN, and clear takes priority.
    always_comb begin
        binary_d   = bin_synced;
        delta_d    = '0;
        advanced_d = 1'b0;
        valid_d    = (state_next == RUN);
        error_d    = error;
        if (clear) begin
            error_d = 1'b0;
        end else if (state == RUN) begin
            delta_d    = bin_synced - bin_prev;
            advanced_d = (delta_d != '0);
            if (multi_change) begin
                error_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_pointer_receiver.sv
// Self-checking bench for gray_pointer_receiver. It uses a table of directed vectors,
// hand-written corner sequences, and a randomized walk checked against a delay-line model.
module tb_gray_pointer_receiver;
    import gray_code_pkg::*;

    localparam int unsigned W = 4;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] gray_in;
    logic         clear;
    logic [W-1:0] binary_out;
    logic [W-1:0] delta;
    logic         advanced;
    logic         valid;
    logic         error;

    always #5 clk = ~clk;

    gray_pointer_receiver #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .clear      (clear),
        .binary_out (binary_out),
        .delta      (delta),
        .advanced   (advanced),
        .valid      (valid),
        .error      (error)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: cap[k] holds the gray value captured k edges ago.
    // 'since' counts the edges since the last reset or clear.
    logic [W-1:0] cap [S+2];
    int           since;
    logic [W-1:0] m_bin, m_delta;
    logic         m_adv, m_valid, m_err;

    typedef struct {
        logic [W-1:0] g;
        logic         c;
        logic [W-1:0] bin;
        logic [W-1:0] dlt;
        logic         adv;
        logic         vld;
        logic         err;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int gray_dec(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            if (W'(binary_to_gray(MAX_WIDTH'(b))) == g) return b;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] enc(input int b);
        return W'(binary_to_gray(MAX_WIDTH'(b)));
    endfunction

    function automatic int ones(input logic [W-1:0] v);
        int n = 0;
        for (int k = 0; k < int'(W); k++) if (v[k]) n++;
        return n;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] g, input logic [W-1:0] bin,
                                input logic [W-1:0] dlt, input logic adv, input logic vld);
        vec_t v;
        v.g = g; v.c = 1'b0; v.bin = bin; v.dlt = dlt; v.adv = adv; v.vld = vld; v.err = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(S) + 2; k++) cap[k] = '0;
        since = 0;
        m_bin = '0; m_delta = '0; m_adv = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge(input logic [W-1:0] g, input logic c);
        logic run_before;
        int   a, b;
        run_before = (since >= int'(S));
        for (int k = int'(S) + 1; k > 0; k--) cap[k] = cap[k-1];
        cap[0] = g;
        a = gray_dec(cap[S]);
        b = gray_dec(cap[S+1]);
        m_bin   = W'(a);
        m_delta = '0;
        m_adv   = 1'b0;
        if (c) begin
            m_err = 1'b0;
        end else if (run_before) begin
            m_delta = W'((a - b + (1 << W)) % (1 << W));
            m_adv   = (m_delta != 0);
            if (ones(cap[S] ^ cap[S+1]) > 1) m_err = 1'b1;
        end
        since   = c ? 0 : (since < 1000 ? since + 1 : since);
        m_valid = (since >= int'(S));
    endtask

    task automatic check_model();
        chk("model_bin",   32'(binary_out), 32'(m_bin));
        chk("model_delta", 32'(delta),      32'(m_delta));
        chk("model_adv",   32'(advanced),   32'(m_adv));
        chk("model_valid", 32'(valid),      32'(m_valid));
        chk("model_err",   32'(error),      32'(m_err));
    endtask

    task automatic tick(input logic [W-1:0] g, input logic c);
        gray_in = g;
        clear   = c;
        @(posedge clk);
        model_edge(g, c);
        #1;
        check_model();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_bin"},   32'(binary_out), 32'd0);
        chk({tag, "_delta"}, 32'(delta),      32'd0);
        chk({tag, "_adv"},   32'(advanced),   32'd0);
        chk({tag, "_valid"}, 32'(valid),      32'd0);
        chk({tag, "_err"},   32'(error),      32'd0);
    endtask

    initial begin
        int p;
        int r;

        // Reset release followed by the single-step walk 0,1,2,3,4.
        tbl[0]  = mk(4'b0000, 4'd0, 4'd0, 1'b0, 1'b0);
        tbl[1]  = mk(4'b0000, 4'd0, 4'd0, 1'b0, 1'b1);
        tbl[2]  = mk(4'b0001, 4'd0, 4'd0, 1'b0, 1'b1);
        tbl[3]  = mk(4'b0001, 4'd0, 4'd0, 1'b0, 1'b1);
        tbl[4]  = mk(4'b0001, 4'd1, 4'd1, 1'b1, 1'b1);
        tbl[5]  = mk(4'b0001, 4'd1, 4'd0, 1'b0, 1'b1);
        tbl[6]  = mk(4'b0011, 4'd1, 4'd0, 1'b0, 1'b1);
        tbl[7]  = mk(4'b0011, 4'd1, 4'd0, 1'b0, 1'b1);
        tbl[8]  = mk(4'b0011, 4'd2, 4'd1, 1'b1, 1'b1);
        tbl[9]  = mk(4'b0011, 4'd2, 4'd0, 1'b0, 1'b1);
        tbl[10] = mk(4'b0010, 4'd2, 4'd0, 1'b0, 1'b1);
        tbl[11] = mk(4'b0010, 4'd2, 4'd0, 1'b0, 1'b1);
        tbl[12] = mk(4'b0010, 4'd3, 4'd1, 1'b1, 1'b1);
        tbl[13] = mk(4'b0010, 4'd3, 4'd0, 1'b0, 1'b1);
        tbl[14] = mk(4'b0110, 4'd3, 4'd0, 1'b0, 1'b1);
        tbl[15] = mk(4'b0110, 4'd3, 4'd0, 1'b0, 1'b1);
        tbl[16] = mk(4'b0110, 4'd4, 4'd1, 1'b1, 1'b1);
        tbl[17] = mk(4'b0110, 4'd4, 4'd0, 1'b0, 1'b1);

        rst_n   = 1'b0;
        gray_in = '0;
        clear   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].g, tbl[i].c);
            chk($sformatf("tbl%0d_bin", i),   32'(binary_out), 32'(tbl[i].bin));
            chk($sformatf("tbl%0d_delta", i), 32'(delta),      32'(tbl[i].dlt));
            chk($sformatf("tbl%0d_adv", i),   32'(advanced),   32'(tbl[i].adv));
            chk($sformatf("tbl%0d_valid", i), 32'(valid),      32'(tbl[i].vld));
            chk($sformatf("tbl%0d_err", i),   32'(error),      32'(tbl[i].err));
        end

        // Assert the async reset between clock edges while the walk is in progress.
        tick(4'b0111, 1'b0);
        #2;
        rst_n   = 1'b0;
        gray_in = '0;
        model_reset();
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b0000, 1'b0);
        chk("refill_valid0", 32'(valid), 32'd0);
        tick(4'b0000, 1'b0);
        chk("refill_valid1", 32'(valid), 32'd1);
        chk("refill_delta",  32'(delta), 32'd0);

        // Hold the input constant in RUN.
        repeat (4) tick(4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0001, 1'b0);
            chk("hold_adv",   32'(advanced),   32'd0);
            chk("hold_delta", 32'(delta),      32'd0);
            chk("hold_bin",   32'(binary_out), 32'd1);
            chk("hold_err",   32'(error),      32'd0);
        end

        // Wrap 14 -> 15 -> 0. Gray 0001 -> 1001 is a single-bit move.
        repeat (4) tick(4'b1001, 1'b0);
        chk("wrap14_bin", 32'(binary_out), 32'd14);
        chk("wrap14_err", 32'(error),      32'd0);
        repeat (2) tick(4'b1000, 1'b0);
        tick(4'b1000, 1'b0);
        chk("wrap15_bin",   32'(binary_out), 32'd15);
        chk("wrap15_delta", 32'(delta),      32'd1);
        chk("wrap15_adv",   32'(advanced),   32'd1);
        tick(4'b1000, 1'b0);
        repeat (2) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        chk("wrap0_bin",   32'(binary_out), 32'd0);
        chk("wrap0_delta", 32'(delta),      32'd1);
        chk("wrap0_adv",   32'(advanced),   32'd1);
        chk("wrap0_err",   32'(error),      32'd0);
        tick(4'b0000, 1'b0);

        // Double jump 0000 -> 0011: the error flag is sticky until clear.
        repeat (2) tick(4'b0011, 1'b0);
        tick(4'b0011, 1'b0);
        chk("jump_bin",   32'(binary_out), 32'd2);
        chk("jump_delta", 32'(delta),      32'd2);
        chk("jump_adv",   32'(advanced),   32'd1);
        chk("jump_err",   32'(error),      32'd1);
        tick(4'b0011, 1'b0);
        repeat (2) tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        chk("sticky_delta", 32'(delta),      32'd1);
        chk("sticky_bin",   32'(binary_out), 32'd3);
        chk("sticky_err",   32'(error),      32'd1);
        tick(4'b0010, 1'b1);
        chk("clr_valid0", 32'(valid), 32'd0);
        chk("clr_err",    32'(error), 32'd0);
        tick(4'b0010, 1'b0);
        chk("clr_valid1", 32'(valid), 32'd0);
        tick(4'b0010, 1'b0);
        chk("clr_valid2", 32'(valid), 32'd1);
        chk("clr_delta",  32'(delta), 32'd0);
        chk("clr_err2",   32'(error), 32'd0);

        // A clear during FILL restarts the fill count.
        tick(4'b0010, 1'b1);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b1);
        chk("refill_clr_v0", 32'(valid), 32'd0);
        tick(4'b0010, 1'b0);
        chk("refill_clr_v1", 32'(valid), 32'd0);
        tick(4'b0010, 1'b0);
        chk("refill_clr_v2", 32'(valid), 32'd1);

        // A clear in the same cycle as a multi-bit change: the clear wins.
        repeat (2) tick(4'b0101, 1'b0);
        tick(4'b0101, 1'b1);
        chk("clr_vs_err", 32'(error), 32'd0);
        repeat (2) tick(4'b0101, 1'b0);
        chk("clr_vs_err_after", 32'(error), 32'd0);

        // Randomized walk: holds, single steps, occasional jumps and clears.
        p = 6;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      p = p;
            else if (r < 88) p = (p + 1) % (1 << W);
            else if (r < 94) p = int'($urandom_range(0, (1 << W) - 1));
            tick(enc(p), (r >= 96) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
